mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: Words, 1024, number of Xlen-bit storage words (power of two).
REQ-002 SHALL have parameter: Latency, 1, cycles from request accept to earliest response valid (legal 1..4).
REQ-003 SHALL have parameter: Outstanding, 4, maximum accepted-but-unreturned requests (power of two, >= Latency).
REQ-004 SHALL have clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have req_valid_i  in  1  request present.
REQ-007 SHALL have req_ready_o  out  1  request can be accepted this cycle.
REQ-008 SHALL have req_type_i  in  mem_type_e  MemLoad, MemStore or MemNone.
REQ-009 SHALL have req_addr_i  in  Xlen  byte address.
REQ-010 SHALL have req_wdata_i  in  Xlen  store data.
REQ-011 SHALL have req_mask_i  in  MaskBits  store byte enables, bit i covers byte i.
REQ-012 SHALL have rsp_valid_o  out  1  response present.
REQ-013 SHALL have rsp_ready_i  in  1  consumer takes response.
REQ-014 SHALL have rsp_rdata_o  out  Xlen  load data, zero for stores and errors.
REQ-015 SHALL have rsp_err_o  out  1  request was out of range or MemNone.

Function
REQ-016 SHALL accept a request exactly when req_valid_i && req_ready_o at a rising edge; one request per cycle max.
REQ-017 SHALL drive req_ready_o = (outstanding count < Outstanding), purely from registered state, independent of req_valid_i.
REQ-018 SHALL increment outstanding on accept, decrement on response handshake (rsp_valid_o && rsp_ready_i), and leave it unchanged when both occur in the same cycle.
REQ-019 SHALL index storage with word = req_addr_i[$clog2(Words)+2:3]; req_addr_i[2:0] ignored.
REQ-020 SHALL flag error when any req_addr_i bit above $clog2(Words)+2 is set, or type is MemNone; errored requests do not touch storage and return rdata 0.
REQ-021 SHALL, for an accepted in-range MemStore, write byte i of the word from req_wdata_i iff req_mask_i[i], at the accept edge; mask 0 is a legal no-op write.
REQ-022 SHALL, for an accepted in-range MemLoad, sample the full word at the accept edge, so a load accepted in the cycle after a store to the same word returns the stored data.
REQ-023 SHALL carry each accepted request's {rdata, err} through a Latency-stage valid pipeline into a response FIFO of depth Outstanding; FIFO never overflows due to REQ-017.
REQ-024 SHALL present rsp_valid_o = FIFO not empty, rsp data from FIFO head, held stable while rsp_valid_o && !rsp_ready_i.
REQ-025 SHALL return responses strictly in accept order.
REQ-026 SHALL, with rsp_ready_i held 1, give a single request rsp_valid_o exactly Latency cycles after its accept edge, and sustain one response per cycle under back-to-back requests.
REQ-027 SHALL allow FIFO push and pop in the same cycle, including when full (pop frees the slot) and when empty (push visible next cycle).

Reset
REQ-028 SHALL, on rst_ni low, asynchronously clear outstanding, pipeline valids and FIFO pointers: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-029 SHALL discard all in-flight requests on reset mid-operation; completed store writes persist; storage array is not reset.

Structure
REQ-030 SHALL import Xlen, MaskBits and mem_type_e from core_pkg; no new package types required.
REQ-031 SHALL instantiate one sub-module, resp_fifo (parameterised depth/width, full/empty, same clock and reset).

Verification
REQ-032 Store addr 0x10, wdata 0x1122334455667788, mask 0xFF; load 0x10 next cycle -> load rsp rdata 0x1122334455667788, err 0.
REQ-033 Store addr 0x10, wdata all-ones, mask 0x0F, after REQ-032 -> load returns 0x11223344FFFFFFFF.
REQ-034 Load addr Words*8 (out of range) and a MemNone request -> both rsp err 1, rdata 0, storage unchanged.
REQ-035 rsp_ready_i=0, req_valid_i=1 continuously -> exactly Outstanding accepts, then req_ready_o=0; raise rsp_ready_i -> responses in order, ready returns 1 cycle after first pop.
REQ-036 Latency=3, rsp_ready_i=1, 8 back-to-back loads -> first rsp_valid_o 3 cycles after first accept, then 8 consecutive valid cycles.
REQ-037 Assert rst_ni low with 3 requests outstanding -> rsp_valid_o=0 immediately, req_ready_o=1 after release, no stale responses emerge.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared memory-port types plus the byte-merge helper used by the responder.
// core_pkg carries the core-wide types; mem_responder_pkg adds block-local helpers.
package core_pkg;
    localparam int Xlen     = 64;
    localparam int MaskBits = Xlen / 8;

    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_type_e;
endpackage

package mem_responder_pkg;
    import core_pkg::*;

    function automatic logic [Xlen-1:0] merge_bytes(
        input logic [Xlen-1:0]     old_word,
        input logic [Xlen-1:0]     new_word,
        input logic [MaskBits-1:0] mask
    );
        logic [Xlen-1:0] res;
        res = old_word;
        for (int i = 0; i < MaskBits; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a memory client (master) and mem_responder (slave).
interface mem_responder_if;
    logic                           req_valid_i;
    logic                           req_ready_o;
    core_pkg::mem_type_e            req_type_i;
    logic [core_pkg::Xlen-1:0]      req_addr_i;
    logic [core_pkg::Xlen-1:0]      req_wdata_i;
    logic [core_pkg::MaskBits-1:0]  req_mask_i;
    logic                           rsp_valid_o;
    logic                           rsp_ready_i;
    logic [core_pkg::Xlen-1:0]      rsp_rdata_o;
    logic                           rsp_err_o;

    modport master (
        output req_valid_i, req_type_i, req_addr_i, req_wdata_i, req_mask_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_type_i, req_addr_i, req_wdata_i, req_mask_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/mem_responder_resp_fifo.sv
// In-order response FIFO; push and pop may coincide, including at full and empty.
module resp_fifo #(
    parameter int Depth = 4,
    parameter int Width = 65
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_r [Depth];
    logic [AW-1:0]    wr_r;
    logic [AW-1:0]    rd_r;
    logic [CW-1:0]    cnt_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        if (p == AW'(Depth - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Qualify the raw requests against occupancy; a pop frees the slot a full push needs.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign empty = (cnt_r == {CW{1'b0}});
    assign full  = (cnt_r == CW'(Depth));
    assign rdata = mem_r[rd_r];

    // Storage, pointers and occupancy; storage cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_r  <= {AW{1'b0}};
            rd_r  <= {AW{1'b0}};
            cnt_r <= {CW{1'b0}};
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {Width{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_r] <= wdata;
                wr_r        <= bump(wr_r);
            end
            if (do_pop_s) begin
                rd_r <= bump(rd_r);
            end
            if (do_push_s && !do_pop_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else if (!do_push_s && do_pop_s) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: byte-masked stores, full-word loads, in-order
// responses after a fixed latency, with back-pressure bounded by an outstanding count.
module mem_responder
    import core_pkg::*;
    import mem_responder_pkg::*;
#(
    parameter int Words       = 1024,
    parameter int Latency     = 1,
    parameter int Outstanding = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    mem_responder_if.slave bus
);
    localparam int IdxW = $clog2(Words);
    localparam int CntW = $clog2(Outstanding + 1);
    localparam int RspW = Xlen + 1;

    logic [Xlen-1:0] store_r [Words];
    logic [CntW-1:0] cnt_r;
    logic            ready_r;
    logic [CntW-1:0] cnt_next_s;
    logic            accept_s;
    logic            pop_s;
    logic            in_range_s;
    logic            write_s;
    logic [IdxW-1:0] idx_s;
    logic [RspW-1:0] rsp_s;
    logic            push_s;
    logic [RspW-1:0] push_dat_s;
    logic            fifo_push_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [RspW-1:0] fifo_head_s;

    // Decode the request, form its {rdata, err} response and the next outstanding count.
    always_comb begin
        accept_s   = bus.req_valid_i && ready_r;
        pop_s      = !fifo_empty_s && bus.rsp_ready_i;
        idx_s      = bus.req_addr_i[IdxW+2:3];
        in_range_s = ((bus.req_addr_i >> (IdxW + 3)) == {Xlen{1'b0}});
        write_s    = 1'b0;
        case (bus.req_type_i)
            MemLoad: begin
                rsp_s = in_range_s ? {store_r[idx_s], 1'b0} : {{Xlen{1'b0}}, 1'b1};
            end
            MemStore: begin
                rsp_s   = {{Xlen{1'b0}}, !in_range_s};
                write_s = accept_s && in_range_s;
            end
            default: begin
                rsp_s = {{Xlen{1'b0}}, 1'b1};
            end
        endcase
        if (accept_s && !pop_s) begin
            cnt_next_s = cnt_r + CntW'(1);
        end else if (!accept_s && pop_s) begin
            cnt_next_s = cnt_r - CntW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Storage array is deliberately not reset so committed stores survive a reset.
    always_ff @(posedge clk_i) begin
        if (write_s) begin
            store_r[idx_s] <= merge_bytes(store_r[idx_s], bus.req_wdata_i, bus.req_mask_i);
        end
    end

    // Outstanding count and registered ready; accept and pop in one cycle cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r   <= {CntW{1'b0}};
            ready_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_next_s;
            ready_r <= (cnt_next_s < CntW'(Outstanding));
        end
    end

    // The FIFO write is the last latency stage, so only Latency-1 extra stages sit before it.
    if (Latency == 1) begin : g_direct
        assign push_s     = accept_s;
        assign push_dat_s = rsp_s;
    end else begin : g_pipe
        logic [Latency-2:0] vld_r;
        logic [RspW-1:0]    dat_r [Latency-1];

        // Shift accepted responses toward the FIFO, one stage per cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_r <= {(Latency-1){1'b0}};
                for (int i = 0; i < Latency - 1; i++) begin
                    dat_r[i] <= {RspW{1'b0}};
                end
            end else begin
                vld_r[0] <= accept_s;
                dat_r[0] <= rsp_s;
                for (int i = 1; i < Latency - 1; i++) begin
                    vld_r[i] <= vld_r[i-1];
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end

        assign push_s     = vld_r[Latency-2];
        assign push_dat_s = dat_r[Latency-2];
    end

    assign fifo_push_s = push_s && (!fifo_full_s || pop_s);

    resp_fifo #(
        .Depth (Outstanding),
        .Width (RspW)
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push_s),
        .wdata  (push_dat_s),
        .pop    (pop_s),
        .rdata  (fifo_head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign bus.req_ready_o = ready_r;
    assign bus.rsp_valid_o = !fifo_empty_s;
    assign bus.rsp_rdata_o = fifo_head_s[RspW-1:1];
    assign bus.rsp_err_o   = fifo_head_s[0];
endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder against a queue-based reference model.
module tb_mem_responder;
    import core_pkg::*;

    localparam int WORDS = 1024;
    localparam int LAT   = 3;
    localparam int OUT   = 4;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   now = 0;
    int   num_checks = 0;
    int   num_fails = 0;

    exp_t        q[$];
    logic [63:0] mdl_mem [WORDS];

    int          obs_accepts, obs_valid_cycles;
    int          first_accept_now, first_valid_now, last_valid_now;
    int          first_pop_now, ready_back_now;
    logic [63:0] last_pop_rdata;
    logic        last_pop_err;

    mem_responder_if bus();

    mem_responder #(
        .Words       (WORDS),
        .Latency     (LAT),
        .Outstanding (OUT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) now <= now + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic reset_tracking();
        obs_accepts      = 0;
        obs_valid_cycles = 0;
        first_accept_now = -1;
        first_valid_now  = -1;
        last_valid_now   = -1;
        first_pop_now    = -1;
        ready_back_now   = -1;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic drive_cycle(input logic v, input mem_type_e t, input logic [63:0] a,
                               input logic [63:0] wd, input logic [7:0] m, input logic rr);
        logic        exp_valid;
        logic        exp_ready;
        exp_t        e;
        logic [63:0] bm;
        int          w;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (q[0].due <= now);
        exp_ready = (q.size() < OUT);
        check_eq("rsp_valid", {63'd0, bus.rsp_valid_o}, {63'd0, exp_valid});
        check_eq("req_ready", {63'd0, bus.req_ready_o}, {63'd0, exp_ready});
        if (exp_valid) begin
            check_eq("rsp_rdata", bus.rsp_rdata_o, q[0].rdata);
            check_eq("rsp_err", {63'd0, bus.rsp_err_o}, {63'd0, q[0].err});
        end
        if (first_pop_now >= 0 && ready_back_now < 0 && bus.req_ready_o) ready_back_now = now;
        if (bus.rsp_valid_o) begin
            obs_valid_cycles++;
            if (first_valid_now < 0) first_valid_now = now;
            last_valid_now = now;
            if (rr) begin
                last_pop_rdata = bus.rsp_rdata_o;
                last_pop_err   = bus.rsp_err_o;
                if (first_pop_now < 0) first_pop_now = now;
            end
        end
        if (v && bus.req_ready_o) begin
            obs_accepts++;
            if (first_accept_now < 0) first_accept_now = now;
        end
        bus.req_valid_i = v;
        bus.req_type_i  = t;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        bus.req_mask_i  = m;
        bus.rsp_ready_i = rr;
        if (exp_valid && rr) void'(q.pop_front());
        if (v && exp_ready) begin
            e.rdata = 64'd0;
            e.err   = 1'b1;
            e.due   = now + LAT;
            if (a < 64'(WORDS * 8) && t != MemNone) begin
                w     = int'(a / 64'd8);
                e.err = 1'b0;
                if (t == MemLoad) begin
                    e.rdata = mdl_mem[w];
                end else begin
                    bm = 64'd0;
                    for (int b = 0; b < 8; b++) if (m[b]) bm = bm | (64'hFF << (8 * b));
                    mdl_mem[w] = (mdl_mem[w] & ~bm) | (wd & bm);
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, MemNone, 64'd0, 64'd0, 8'd0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
        idle(1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        check_eq("rst_rdata", bus.rsp_rdata_o, 64'd0);
        check_eq("rst_err", {63'd0, bus.rsp_err_o}, 64'd0);
        check_eq("rst_ready", {63'd0, bus.req_ready_o}, 64'd1);
        q.delete();
        bus.req_valid_i = 1'b0;
        bus.req_type_i  = MemNone;
        bus.req_addr_i  = 64'd0;
        bus.req_wdata_i = 64'd0;
        bus.req_mask_i  = 8'd0;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] wd;
        mem_type_e   t;
        reset_tracking();
        last_pop_rdata = 64'd0;
        last_pop_err   = 1'b0;
        apply_reset();

        for (int w = 0; w < 16; w++) begin
            drive_cycle(1'b1, MemStore, 64'(w * 8), {$urandom, $urandom}, 8'hFF, 1'b1);
        end
        drain();

        drive_cycle(1'b1, MemStore, 64'h10, 64'h1122334455667788, 8'hFF, 1'b1);
        drive_cycle(1'b1, MemLoad, 64'h10, 64'd0, 8'h00, 1'b1);
        drain();
        check_eq("full_store_load", last_pop_rdata, 64'h1122334455667788);
        check_eq("full_store_err", {63'd0, last_pop_err}, 64'd0);

        drive_cycle(1'b1, MemStore, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1);
        drive_cycle(1'b1, MemLoad, 64'h15, 64'd0, 8'h00, 1'b1);
        drain();
        check_eq("masked_store_load", last_pop_rdata, 64'h11223344FFFFFFFF);

        drive_cycle(1'b1, MemLoad, 64'(WORDS * 8), 64'd0, 8'h00, 1'b1);
        drain();
        check_eq("oor_load_err", {63'd0, last_pop_err}, 64'd1);
        check_eq("oor_load_rdata", last_pop_rdata, 64'd0);
        drive_cycle(1'b1, MemNone, 64'h10, 64'h5555, 8'hFF, 1'b1);
        drain();
        check_eq("none_err", {63'd0, last_pop_err}, 64'd1);
        check_eq("none_rdata", last_pop_rdata, 64'd0);
        drive_cycle(1'b1, MemStore, 64'(WORDS * 8 + 16), 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
        drive_cycle(1'b1, MemLoad, 64'h10, 64'd0, 8'h00, 1'b1);
        drain();
        check_eq("oor_store_noop", last_pop_rdata, 64'h11223344FFFFFFFF);

        reset_tracking();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, MemLoad, 64'h8, 64'd0, 8'h00, 1'b0);
        #1;
        check_eq("fill_accepts", 64'(obs_accepts), 64'(OUT));
        check_eq("fill_ready_low", {63'd0, bus.req_ready_o}, 64'd0);
        drain();
        check_eq("ready_after_pop", 64'(ready_back_now - first_pop_now), 64'd1);

        reset_tracking();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, MemLoad, 64'(i * 8), 64'd0, 8'h00, 1'b1);
        idle(12);
        check_eq("b2b_accepts", 64'(obs_accepts), 64'd8);
        check_eq("b2b_first_lat", 64'(first_valid_now - first_accept_now), 64'(LAT));
        check_eq("b2b_valid_cycles", 64'(obs_valid_cycles), 64'd8);
        check_eq("b2b_contiguous", 64'(last_valid_now - first_valid_now), 64'd7);

        for (int i = 0; i < 600; i++) begin
            a = 64'($urandom_range(15, 0) * 8 + $urandom_range(7, 0));
            if ($urandom_range(9, 0) == 0) a = a | (64'd1 << $urandom_range(63, 13));
            case ($urandom_range(4, 0))
                0:       t = MemNone;
                1, 2:    t = MemStore;
                default: t = MemLoad;
            endcase
            wd = {$urandom, $urandom};
            drive_cycle($urandom_range(9, 0) < 7, t, a, wd, 8'($urandom_range(255, 0)),
                        $urandom_range(9, 0) < 6);
        end
        drain();

        for (int i = 0; i < 3; i++) drive_cycle(1'b1, MemLoad, 64'(i * 8), 64'd0, 8'h00, 1'b0);
        drive_cycle(1'b0, MemNone, 64'd0, 64'd0, 8'd0, 1'b0);
        apply_reset();
        reset_tracking();
        idle(10);
        check_eq("no_stale_rsp", 64'(obs_valid_cycles), 64'd0);
        drive_cycle(1'b1, MemLoad, 64'h10, 64'd0, 8'h00, 1'b1);
        drain();
        check_eq("post_reset_load", last_pop_rdata, mdl_mem[2]);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
        $finish;
    end
endmodule
